branch_predictor: RTL and testbench

- Direction predictor and BTB controller wrapped around the direct-mapped, untagged 1024-entry BTB in the fetch stage.
- Consumes the BTB's synchronous read data and produces the fetch next-PC prediction.
- Resolves branches arriving from EX: detects mispredictions, drives flush/redirect, and generates the BTB write port (load_btb, write PC, write target).
- Owns the valid bits and 2-bit saturating counters the BTB lacks.

---
 rtl/branch_predictor_if.sv | 40 ++++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side resolution and BTB write signals shared by the
// branch predictor and the pipeline around it.
interface branch_predictor_if;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_stall;
    logic [31:0] btb_target;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        load_btb;
    logic [31:0] btb_wr_pc;
    logic [31:0] btb_wr_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    modport slave (
        input  fetch_pc, fetch_valid, fetch_stall, btb_target,
        input  ex_valid, ex_is_br, ex_pc, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output pred_taken, pred_pc, load_btb, btb_wr_pc, btb_wr_target,
        output flush, redirect_pc, br_count, mispred_count
    );

    modport master (
        output fetch_pc, fetch_valid, fetch_stall, btb_target,
        output ex_valid, ex_is_br, ex_pc, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_pc, load_btb, btb_wr_pc, btb_wr_target,
        input  flush, redirect_pc, br_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direction predictor and BTB controller: owns valid bits and 2-bit counters
// for an untagged direct-mapped BTB, predicts next PC and resolves EX branches.
module branch_predictor #(
    parameter int         IDX_BITS = 10,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 2 ** IDX_BITS;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] r;
        if (up) begin
            r = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            r = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return r;
    endfunction

    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] ctr_q;
    logic [31:0]             lk_pc_q;
    logic                    lk_valid_q;
    logic                    lk_hit_q;
    logic [1:0]              lk_ctr_q;
    logic [31:0]             br_count_q;
    logic [31:0]             mispred_count_q;

    logic [IDX_BITS-1:0] ex_idx_s;
    logic [IDX_BITS-1:0] fetch_idx_s;
    logic                resolve_s;
    logic                mispred_s;
    logic                alias_s;
    logic                flush_s;
    logic [31:0]         redirect_s;
    logic [1:0]          ctr_d;
    logic                valid_d;

    assign ex_idx_s    = bp.ex_pc[IDX_BITS-1:0];
    assign fetch_idx_s = bp.fetch_pc[IDX_BITS-1:0];

    // EX resolution: mispredict/alias detection, redirect and entry next-state.
    always_comb begin
        resolve_s  = bp.ex_valid & bp.ex_is_br;
        mispred_s  = resolve_s & ((bp.ex_taken != bp.ex_pred_taken) |
                     (bp.ex_taken & bp.ex_pred_taken & (bp.ex_pred_target != bp.ex_target)));
        alias_s    = bp.ex_valid & ~bp.ex_is_br & bp.ex_pred_taken;
        flush_s    = mispred_s | alias_s;
        redirect_s = 32'd0;
        ctr_d      = ctr_q[ex_idx_s];
        valid_d    = valid_q[ex_idx_s];
        if (flush_s) begin
            redirect_s = (resolve_s & bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
        end else begin
            redirect_s = 32'd0;
        end
        // An alias means a non-branch hit a stale entry; scrub it back to reset.
        if (resolve_s) begin
            ctr_d   = ctr_step(ctr_q[ex_idx_s], bp.ex_taken);
            valid_d = valid_q[ex_idx_s] | bp.ex_taken;
        end else if (alias_s) begin
            ctr_d   = CTR_INIT;
            valid_d = 1'b0;
        end else begin
            ctr_d   = ctr_q[ex_idx_s];
            valid_d = valid_q[ex_idx_s];
        end
    end

    // Predictor state: table update, lookup register and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= '0;
            ctr_q           <= {ENTRIES{CTR_INIT}};
            lk_pc_q         <= 32'd0;
            lk_valid_q      <= 1'b0;
            lk_hit_q        <= 1'b0;
            lk_ctr_q        <= CTR_INIT;
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            valid_q[ex_idx_s] <= valid_d;
            ctr_q[ex_idx_s]   <= ctr_d;
            // Lookup reads the pre-update table, matching the BTB's read-old behaviour.
            if (!bp.fetch_stall) begin
                lk_pc_q  <= bp.fetch_pc;
                lk_hit_q <= valid_q[fetch_idx_s];
                lk_ctr_q <= ctr_q[fetch_idx_s];
            end else begin
                lk_pc_q  <= lk_pc_q;
                lk_hit_q <= lk_hit_q;
                lk_ctr_q <= lk_ctr_q;
            end
            if (flush_s) begin
                lk_valid_q <= 1'b0;
            end else if (!bp.fetch_stall) begin
                lk_valid_q <= bp.fetch_valid;
            end else begin
                lk_valid_q <= lk_valid_q;
            end
            br_count_q      <= br_count_q + {31'd0, resolve_s};
            mispred_count_q <= mispred_count_q + {31'd0, flush_s};
        end
    end

    assign bp.pred_taken    = lk_valid_q & lk_hit_q & lk_ctr_q[1];
    assign bp.pred_pc       = bp.pred_taken ? bp.btb_target : lk_pc_q + 32'd4;
    assign bp.load_btb      = resolve_s & bp.ex_taken;
    assign bp.btb_wr_pc     = bp.ex_pc;
    assign bp.btb_wr_target = bp.ex_target;
    assign bp.flush         = flush_s;
    assign bp.redirect_pc   = redirect_s;
    assign bp.br_count      = br_count_q;
    assign bp.mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    branch_predictor_if bp ();

    branch_predictor #(.IDX_BITS(10), .CTR_INIT(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        bp.ex_valid = 1'b0; bp.ex_is_br = 1'b0; bp.ex_pc = 32'd0; bp.ex_taken = 1'b0;
        bp.ex_target = 32'd0; bp.ex_pred_taken = 1'b0; bp.ex_pred_target = 32'd0;
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bp.ex_valid = v; bp.ex_is_br = br; bp.ex_pc = pc; bp.ex_taken = tk;
        bp.ex_target = tgt; bp.ex_pred_taken = ptk; bp.ex_pred_target = ptgt;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic v);
        bp.fetch_pc = pc; bp.fetch_valid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bp.fetch_stall = 1'b0; bp.btb_target = 32'd0;
        fetch(32'd0, 1'b0); ex_idle();
        #2;
        total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred_taken: got %b want 0", bp.pred_taken); end
        total++; if (bp.pred_pc !== 32'h4) begin bad++; $display("FAIL rst_pred_pc: got %h want 00000004", bp.pred_pc); end
        total++; if (bp.flush !== 1'b0 || bp.load_btb !== 1'b0) begin bad++; $display("FAIL rst_flush_load: got %b%b want 00", bp.flush, bp.load_btb); end
        total++; if (bp.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect: got %h want 0", bp.redirect_pc); end
        total++; if (bp.br_count !== 32'd0 || bp.mispred_count !== 32'd0) begin bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", bp.br_count, bp.mispred_count); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lookup_miss();
        fetch(32'h100, 1'b1);
        tick();
        fetch(32'h0, 1'b0);
        #1;
        total++; if (bp.pred_taken !== 1'b0) begin bad++; $display("FAIL miss_taken: got %b want 0", bp.pred_taken); end
        total++; if (bp.pred_pc !== 32'h104) begin bad++; $display("FAIL miss_pc: got %h want 00000104", bp.pred_pc); end
        total++; if (bp.flush !== 1'b0 || bp.load_btb !== 1'b0) begin bad++; $display("FAIL miss_flush_load: got %b%b want 00", bp.flush, bp.load_btb); end
    endtask

    task automatic test_resolve_taken();
        ex_drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        total++; if (bp.flush !== 1'b1) begin bad++; $display("FAIL rt_flush: got %b want 1", bp.flush); end
        total++; if (bp.redirect_pc !== 32'h200) begin bad++; $display("FAIL rt_redirect: got %h want 00000200", bp.redirect_pc); end
        total++; if (bp.load_btb !== 1'b1) begin bad++; $display("FAIL rt_load: got %b want 1", bp.load_btb); end
        total++; if (bp.btb_wr_pc !== 32'h100 || bp.btb_wr_target !== 32'h200) begin bad++; $display("FAIL rt_wr: got %h/%h want 00000100/00000200", bp.btb_wr_pc, bp.btb_wr_target); end
        tick();
        ex_idle(); fetch(32'h100, 1'b1);
        tick();
        fetch(32'h0, 1'b0); bp.btb_target = 32'h200;
        #1;
        total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL rt_refetch_taken: got %b want 1", bp.pred_taken); end
        total++; if (bp.pred_pc !== 32'h200) begin bad++; $display("FAIL rt_refetch_pc: got %h want 00000200", bp.pred_pc); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            ex_drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
            #1;
            total++; if (bp.flush !== 1'b0 || bp.load_btb !== 1'b1) begin bad++; $display("FAIL sat_correct%0d: got flush=%b load=%b want 0 1", i, bp.flush, bp.load_btb); end
            tick();
        end
        ex_drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        #1;
        total++; if (bp.flush !== 1'b1 || bp.load_btb !== 1'b0) begin bad++; $display("FAIL sat_nt_flush: got flush=%b load=%b want 1 0", bp.flush, bp.load_btb); end
        total++; if (bp.redirect_pc !== 32'h104) begin bad++; $display("FAIL sat_nt_redirect: got %h want 00000104", bp.redirect_pc); end
        tick();
        ex_idle(); fetch(32'h100, 1'b1);
        tick();
        fetch(32'h0, 1'b0);
        #1;
        total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL sat_still_taken: got %b want 1", bp.pred_taken); end
    endtask

    task automatic test_target_mismatch();
        ex_drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
        #1;
        total++; if (bp.flush !== 1'b1 || bp.load_btb !== 1'b1) begin bad++; $display("FAIL tm_flush_load: got %b%b want 11", bp.flush, bp.load_btb); end
        total++; if (bp.redirect_pc !== 32'h200) begin bad++; $display("FAIL tm_redirect: got %h want 00000200", bp.redirect_pc); end
        tick();
        ex_idle();
        #1;
        total++; if (bp.br_count !== 32'd7 || bp.mispred_count !== 32'd3) begin bad++; $display("FAIL tm_counts: got %0d/%0d want 7/3", bp.br_count, bp.mispred_count); end
    endtask

    task automatic test_alias();
        ex_drive(1'b1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        total++; if (bp.flush !== 1'b1 || bp.load_btb !== 1'b0) begin bad++; $display("FAIL al_flush_load: got %b%b want 10", bp.flush, bp.load_btb); end
        total++; if (bp.redirect_pc !== 32'h504) begin bad++; $display("FAIL al_redirect: got %h want 00000504", bp.redirect_pc); end
        tick();
        ex_idle(); fetch(32'h100, 1'b1);
        tick();
        fetch(32'h0, 1'b0);
        #1;
        total++; if (bp.pred_taken !== 1'b0 || bp.pred_pc !== 32'h104) begin bad++; $display("FAIL al_lookup: got %b/%h want 0/00000104", bp.pred_taken, bp.pred_pc); end
    endtask

    task automatic test_stall_flush();
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        ex_idle(); fetch(32'h40, 1'b1);
        tick();
        bp.btb_target = 32'h80; bp.fetch_stall = 1'b1; fetch(32'h999, 1'b1);
        #1;
        total++; if (bp.pred_taken !== 1'b1 || bp.pred_pc !== 32'h80) begin bad++; $display("FAIL sf_pre: got %b/%h want 1/00000080", bp.pred_taken, bp.pred_pc); end
        tick();
        total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL sf_hold: got %b want 1", bp.pred_taken); end
        ex_drive(1'b1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b1, 32'h0);
        #1;
        total++; if (bp.flush !== 1'b1 || bp.redirect_pc !== 32'h704) begin bad++; $display("FAIL sf_flush: got %b/%h want 1/00000704", bp.flush, bp.redirect_pc); end
        tick();
        ex_idle();
        #1;
        total++; if (bp.pred_taken !== 1'b0 || bp.pred_pc !== 32'h44) begin bad++; $display("FAIL sf_killed: got %b/%h want 0/00000044", bp.pred_taken, bp.pred_pc); end
        tick();
        bp.fetch_stall = 1'b0; fetch(32'h0, 1'b0);
    endtask

    task automatic test_read_old();
        fetch(32'h40, 1'b1);
        ex_drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h0);
        #1;
        total++; if (bp.flush !== 1'b0 || bp.load_btb !== 1'b0) begin bad++; $display("FAIL ro_flush_load: got %b%b want 00", bp.flush, bp.load_btb); end
        tick();
        ex_idle(); bp.btb_target = 32'h80;
        #1;
        total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL ro_old: got %b want 1", bp.pred_taken); end
        tick();
        total++; if (bp.pred_taken !== 1'b0 || bp.pred_pc !== 32'h44) begin bad++; $display("FAIL ro_new: got %b/%h want 0/00000044", bp.pred_taken, bp.pred_pc); end
        fetch(32'h0, 1'b0);
    endtask

    task automatic test_counters_and_reset();
        ex_drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        ex_idle(); fetch(32'h40, 1'b1);
        tick();
        total++; if (bp.br_count !== 32'd10 || bp.mispred_count !== 32'd7) begin bad++; $display("FAIL cnt: got %0d/%0d want 10/7", bp.br_count, bp.mispred_count); end
        total++; if (bp.pred_taken !== 1'b1) begin bad++; $display("FAIL mr_pre: got %b want 1", bp.pred_taken); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bp.pred_taken !== 1'b0 || bp.pred_pc !== 32'h4) begin bad++; $display("FAIL mr_pred: got %b/%h want 0/00000004", bp.pred_taken, bp.pred_pc); end
        total++; if (bp.br_count !== 32'd0 || bp.mispred_count !== 32'd0) begin bad++; $display("FAIL mr_counts: got %0d/%0d want 0/0", bp.br_count, bp.mispred_count); end
        #1 rst_n = 1'b1;
        tick();
        total++; if (bp.pred_taken !== 1'b0 || bp.pred_pc !== 32'h44) begin bad++; $display("FAIL mr_after: got %b/%h want 0/00000044", bp.pred_taken, bp.pred_pc); end
        fetch(32'h0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lookup_miss();
        test_resolve_taken();
        test_saturate();
        test_target_mismatch();
        test_alias();
        test_stall_flush();
        test_read_old();
        test_counters_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
